// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the banked memory unit.
// Holds the FSM state encoding, access-size codes and latency limit.
package mem_unit_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/mem_unit_bank.sv
// Byte-wide storage bank: synchronous write, registered read.
// dout only moves on a read strobe so it can hold the last result.
module mem_bank #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    input  logic             we,
    input  logic             re,
    input  logic [7:0]       din,
    output logic [7:0]       dout
);

    logic [7:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[index] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset)
            dout <= '0;
        else if (re)
            dout <= mem[index];
    end

endmodule

// File: rtl/mem_unit.sv
// Two-bank byte/word memory with fixed access latency.
// Clears both banks after reset, then serves one access at a time.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 1;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              size_q;
    logic [15:0]       wdata_q;
    logic              err_q;
    logic              rd_word_q;
    logic              rd_hi_q;

    logic              in_idle;
    logic              in_clear;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic              cur_size;
    logic [15:0]       cur_wdata;
    logic              misalign;
    logic              commit;
    logic              lo_sel;
    logic              hi_sel;
    logic [IDX_W-1:0]  bank_idx;
    logic              lo_we;
    logic              hi_we;
    logic              lo_re;
    logic              hi_re;
    logic [7:0]        lo_din;
    logic [7:0]        hi_din;
    logic [7:0]        lo_dout;
    logic [7:0]        hi_dout;

    assign in_idle  = (state == ST_IDLE);
    assign in_clear = (state == ST_CLEAR);

    // In IDLE the live inputs drive the banks so LATENCY=1 can commit
    // on the accepting edge; otherwise the latched request is used.
    assign cur_addr  = in_idle ? addr  : addr_q;
    assign cur_we    = in_idle ? we    : we_q;
    assign cur_size  = in_idle ? size  : size_q;
    assign cur_wdata = in_idle ? wdata : wdata_q;

    assign misalign = (cur_size == SIZE_WORD) && cur_addr[0];

    assign commit = !reset &&
        ((in_idle && req && LATENCY == 1) ||
         (state == ST_WAIT && cnt == 4'd1));

    assign lo_sel = (cur_size == SIZE_WORD) || !cur_addr[0];
    assign hi_sel = (cur_size == SIZE_WORD) || cur_addr[0];

    assign bank_idx = in_clear ? clr_idx : cur_addr[ADDR_W-1:1];

    assign lo_we = (!reset && in_clear) ||
                   (commit && cur_we && !misalign && lo_sel);
    assign hi_we = (!reset && in_clear) ||
                   (commit && cur_we && !misalign && hi_sel);
    assign lo_re = commit && !cur_we && !misalign && lo_sel;
    assign hi_re = commit && !cur_we && !misalign && hi_sel;

    assign lo_din = in_clear ? 8'h00 : cur_wdata[7:0];
    assign hi_din = in_clear ? 8'h00 :
                    (cur_size == SIZE_WORD) ? cur_wdata[15:8]
                                            : cur_wdata[7:0];

    mem_bank #(.IDX_W(IDX_W)) u_lo (
        .clk   (clk),
        .reset (reset),
        .index (bank_idx),
        .we    (lo_we),
        .re    (lo_re),
        .din   (lo_din),
        .dout  (lo_dout)
    );

    mem_bank #(.IDX_W(IDX_W)) u_hi (
        .clk   (clk),
        .reset (reset),
        .index (bank_idx),
        .we    (hi_we),
        .re    (hi_re),
        .din   (hi_din),
        .dout  (hi_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            rd_word_q <= 1'b0;
            rd_hi_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            wdata_q   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    err_q <= 1'b0;
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        size_q  <= size;
                        wdata_q <= wdata;
                        if (LATENCY == 1) begin
                            state <= ST_DONE;
                            err_q <= misalign;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) begin
                        state <= ST_DONE;
                        err_q <= misalign;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
            endcase
            if (lo_re || hi_re) begin
                rd_word_q <= (cur_size == SIZE_WORD);
                rd_hi_q   <= cur_addr[0];
            end
        end
    end

    assign rdata = rd_word_q ? {hi_dout, lo_dout}
                             : {8'h00, rd_hi_q ? hi_dout : lo_dout};
    assign ready = (state == ST_DONE);
    assign err   = err_q;
    assign busy  = in_clear;

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: directed accesses push expectations,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        size = 1'b0;
    logic [8:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int seen = 0;

    typedef struct {
        string       name;
        int          at;
        logic [15:0] rd;
        logic        er;
    } exp_t;

    exp_t sb[$];

    mem_unit #(.ADDR_W(9), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready is seen at the negedge after the (LAT-1)th edge past acceptance.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_lat"}, 32'(cyc), 32'(e.at));
                check({e.name, "_rdata"}, 32'(rdata), 32'(e.rd));
                check({e.name, "_err"}, 32'(err), 32'(e.er));
                seen++;
            end
        end
    end

    task automatic push(input string nm, input int acc,
                        input logic [15:0] rd, input logic er);
        exp_t e;
        e.name = nm;
        e.at   = acc + LAT - 1;
        e.rd   = rd;
        e.er   = er;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (seen < pushed && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (seen < pushed)
            check({nm, "_timeout"}, 32'(seen), 32'(pushed));
    endtask

    task automatic access(input string nm, input logic w, input logic s,
                          input logic [8:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input logic er);
        int acc;
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(posedge clk);
        #1;
        acc = cyc;
        push(nm, acc, rd, er);
        @(negedge clk);
        req = 1'b0;
        wait_done(nm);
    endtask

    task automatic sweep(input string nm, input logic hold_req);
        int n;
        check({nm, "_busy0"}, 32'(busy), 32'd1);
        check({nm, "_rdata0"}, 32'(rdata), 32'd0);
        check({nm, "_ready0"}, 32'(ready), 32'd0);
        check({nm, "_err0"}, 32'(err), 32'd0);
        req = hold_req; we = 1'b0; size = 1'b1; addr = 9'h000;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        check({nm, "_busy_cycles"}, 32'(n), 32'd256);
    endtask

    initial begin
        int acc;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep("rst", 1'b1);

        access("rd_clr0",   1'b0, 1'b1, 9'h000, 16'h0, 16'h0000, 1'b0);
        access("rd_clr1fe", 1'b0, 1'b1, 9'h1FE, 16'h0, 16'h0000, 1'b0);

        access("wr_beef", 1'b1, 1'b1, 9'h010, 16'hBEEF, 16'h0000, 1'b0);
        access("rd_beef", 1'b0, 1'b1, 9'h010, 16'h0,    16'hBEEF, 1'b0);

        access("wrb_5a",  1'b1, 1'b0, 9'h011, 16'hC35A, 16'hBEEF, 1'b0);
        access("rdb_11",  1'b0, 1'b0, 9'h011, 16'h0,    16'h005A, 1'b0);
        access("rd_5aef", 1'b0, 1'b1, 9'h010, 16'h0,    16'h5AEF, 1'b0);
        access("rdb_10",  1'b0, 1'b0, 9'h010, 16'h0,    16'h00EF, 1'b0);
        access("rd_5aef2", 1'b0, 1'b1, 9'h010, 16'h0,   16'h5AEF, 1'b0);

        access("wr_mis",  1'b1, 1'b1, 9'h021, 16'h1234, 16'h5AEF, 1'b1);
        access("rd_mis",  1'b0, 1'b1, 9'h011, 16'h0,    16'h5AEF, 1'b1);
        access("rd_20",   1'b0, 1'b1, 9'h020, 16'h0,    16'h0000, 1'b0);

        access("wrb_lo",  1'b1, 1'b0, 9'h020, 16'hFF77, 16'h0000, 1'b0);
        access("rd_0077", 1'b0, 1'b1, 9'h020, 16'h0,    16'h0077, 1'b0);

        // req held across ready: second access lands 5 cycles later.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 1'b1; addr = 9'h010;
        @(posedge clk);
        #1;
        acc = cyc;
        push("b2b_a", acc, 16'h5AEF, 1'b0);
        push("b2b_b", acc + 5, 16'h5AEF, 1'b0);
        while (cyc < acc + LAT + 4 && cyc < acc + 40)
            @(negedge clk);
        req = 1'b0;
        wait_done("b2b");

        // Reset two cycles into a write aborts it before commit.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 1'b1; addr = 9'h030; wdata = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep("abort", 1'b0);
        access("rd_30", 1'b0, 1'b1, 9'h030, 16'h0, 16'h0000, 1'b0);
        access("rd_10", 1'b0, 1'b1, 9'h010, 16'h0, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: byte-address width; each bank holds 2**(ADDR_W-1) bytes.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request acceptance to ready; legal range 1..15.
REQ-003 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port req  in  1: access request (MIO enable).
REQ-006 SHALL have port we  in  1: 1 = write, 0 = read.
REQ-007 SHALL have port size  in  1: 1 = word (16 bit), 0 = byte.
REQ-008 SHALL have port addr  in  ADDR_W: byte address; addr[0] selects bank (0 = low, 1 = high).
REQ-009 SHALL have port wdata  in  16: write data; byte writes use wdata[7:0].
REQ-010 SHALL have port rdata  out  16: read data.
REQ-011 SHALL have port ready  out  1: one-cycle completion pulse.
REQ-012 SHALL have port err  out  1: misaligned-word flag, valid only while ready = 1.
REQ-013 SHALL have port busy  out  1: high during the post-reset clear sweep.

Function
REQ-014 SHALL implement FSM states CLEAR, IDLE, WAIT, DONE.
REQ-015 CLEAR: one bank index per cycle, 0..DEPTH-1, SHALL be zeroed in both banks; busy = 1; req ignored; after index DEPTH-1, next state IDLE.
REQ-016 IDLE: req = 1 at a posedge SHALL accept the request, latch addr/we/size/wdata and go to WAIT with the counter set to LATENCY-1; req = 0 stays IDLE.
REQ-017 WAIT: the counter SHALL decrement each cycle; at zero, next state DONE; LATENCY = 1 goes from IDLE directly to DONE.
REQ-018 ready SHALL be 1 exactly during DONE, which starts LATENCY cycles after the accepting edge; DONE always returns to IDLE.
REQ-019 A write SHALL commit to the array on the edge entering DONE; a read SHALL load rdata on that same edge.
REQ-020 Word access with addr[0] = 0: low bank byte SHALL map to [7:0] and high bank byte to [15:8] at index addr[ADDR_W-1:1].
REQ-021 Byte read SHALL return the selected bank byte in rdata[7:0] and zero in rdata[15:8].
REQ-022 Byte write SHALL modify only the selected bank.
REQ-023 Word access with addr[0] = 1 SHALL set err = 1 with ready, write nothing and leave rdata unchanged.
REQ-024 rdata SHALL hold its value until the next successful read completes; writes SHALL not change rdata.
REQ-025 req and inputs SHALL be ignored in WAIT and DONE; no queueing.
REQ-026 req still high in IDLE after DONE SHALL start a new access; the requester drops req during ready to avoid this.
REQ-027 Address wrap SHALL not occur; each access touches a single bank index.

Reset
REQ-028 reset = 1 at a posedge SHALL force CLEAR with clear index 0, counter 0, rdata = 0, ready = 0, err = 0 and busy = 1 from the next cycle.
REQ-029 reset during WAIT SHALL abort the access; its pending write SHALL never commit.
REQ-030 reset during CLEAR SHALL restart the sweep at index 0.

Structure
REQ-031 A shared package SHALL hold the state enum, the SIZE_BYTE/SIZE_WORD constants and the LATENCY_MAX = 15 constant.
REQ-032 Sub-module mem_bank (byte-wide, synchronous write, registered read, index/we/din/dout) SHALL be instantiated twice.

Verification (ADDR_W = 9, LATENCY = 4, DEPTH = 256)
REQ-033 Reset pulse -> busy high 256 cycles; req = 1 ignored throughout; then IDLE; a word read of any address returns 0x0000.
REQ-034 Word write 0xBEEF @0x010, then word read @0x010 -> ready exactly 4 cycles after each accepting edge; rdata = 0xBEEF; err = 0.
REQ-035 Byte write 0x5A @0x011, then byte read @0x011 -> rdata = 0x005A; word read @0x010 -> 0x5AEF.
REQ-036 Word write 0x1234 @0x021 -> ready with err = 1; word read @0x020 -> 0x0000; rdata unchanged in between.
REQ-037 Word write 0xAAAA @0x030 with reset asserted 2 cycles after acceptance -> sweep restarts; read @0x030 after busy falls -> 0x0000.
REQ-038 req held high across ready -> a second access is accepted in the IDLE cycle after DONE; ready pulses separated by 5 cycles.
